// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: slot phase, hex glyph table, blank pattern.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

   typedef enum logic {BLANK, ON} phase_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low seven-segment pattern, pure combinational lookup.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for common-anode seven-segment digits with
// frame-synchronous shadow/active data. Define SEG7_DIM_EN for 16-step PWM dimming.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 10000,
   parameter int BLANK_CYCLES = 100
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   dig_en_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
`ifdef SEG7_DIM_EN
   input  logic [3:0]              brightness,
`endif
   output logic                    pending,
   output logic                    frame_start,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp
);

   // Counter is at least 4 bits so the PWM compare always has slot_cnt[3:0].
   localparam int CW = ($clog2(DIGIT_CYCLES) > 4) ? $clog2(DIGIT_CYCLES) : 4;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]           slot_cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] act_digits, sh_digits, nxt_digits;
   logic [NUM_DIGITS-1:0]   act_en, sh_en, nxt_en;
   logic [NUM_DIGITS-1:0]   act_dp, sh_dp, nxt_dp;
   logic                    commit;
   phase_t                  phase;
   logic                    lit;
   logic [6:0]              seg_dec;
   logic [NUM_DIGITS-1:0]   an_nxt;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;

   assign commit = (slot_cnt == '0) && (idx == '0);
   assign phase  = (slot_cnt < BLANK_END) ? BLANK : ON;

   // Display path reads the post-commit data so a frame never mixes old and new.
   always_comb begin
      nxt_digits = act_digits;
      nxt_en     = act_en;
      nxt_dp     = act_dp;
      if (commit) begin
         if (load) begin
            nxt_digits = digits_i;
            nxt_en     = dig_en_i;
            nxt_dp     = dp_i;
         end else if (pending) begin
            nxt_digits = sh_digits;
            nxt_en     = sh_en;
            nxt_dp     = sh_dp;
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble (nxt_digits[4*idx +: 4]),
      .seg    (seg_dec)
   );

   always_comb begin
      lit = (phase == ON) && nxt_en[idx];
`ifdef SEG7_DIM_EN
      lit = lit && (slot_cnt[3:0] < brightness);
`endif
      an_nxt  = '1;
      seg_nxt = SEG_OFF;
      dp_nxt  = 1'b1;
      if (lit) begin
         an_nxt  = ~(NUM_DIGITS'(1) << idx);
         seg_nxt = seg_dec;
         dp_nxt  = ~nxt_dp[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt    <= '0;
         idx         <= '0;
         act_digits  <= '0;
         act_en      <= '0;
         act_dp      <= '0;
         sh_digits   <= '0;
         sh_en       <= '0;
         sh_dp       <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
         an          <= '1;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
      end else begin
         if (slot_cnt == CNT_LAST) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
         act_digits <= nxt_digits;
         act_en     <= nxt_en;
         act_dp     <= nxt_dp;
         if (load) begin
            sh_digits <= digits_i;
            sh_en     <= dig_en_i;
            sh_dp     <= dp_i;
         end
         if (commit)
            pending <= 1'b0;
         else if (load)
            pending <= 1'b1;
         frame_start <= commit;
         an          <= an_nxt;
         seg         <= seg_nxt;
         dp          <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position reference model feeding a scoreboard,
// plus table-driven frame checks and hand sequences for commit/reset corners.
module tb_seg7_scan_ctrl;

   localparam int ND = 4;
   localparam int DC = 8;
   localparam int BC = 2;
   localparam int FRAME = ND * DC;

   logic          clk = 1'b0;
   logic          reset, load;
   logic [15:0]   digits_i;
   logic [3:0]    dig_en_i, dp_i;
`ifdef SEG7_DIM_EN
   logic [3:0]    brightness;
`endif
   logic          pending, frame_start;
   logic [3:0]    an;
   logic [6:0]    seg;
   logic          dp;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .digits_i    (digits_i),
      .dig_en_i    (dig_en_i),
      .dp_i        (dp_i),
`ifdef SEG7_DIM_EN
      .brightness  (brightness),
`endif
      .pending     (pending),
      .frame_start (frame_start),
      .an          (an),
      .seg         (seg),
      .dp          (dp)
   );

   // Standard active-low hex glyphs, gfedcba.
   logic [6:0] glyph [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       pend;
      logic       fs;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: frame position 0..FRAME-1, digit = pos/DC, cycle = pos%DC.
   int          m_pos = 0;
   logic [15:0] m_act_d = '0, m_sh_d = '0;
   logic [3:0]  m_act_en = '0, m_sh_en = '0, m_act_dp = '0, m_sh_dp = '0;
   logic        m_pend = 1'b0;

   always @(posedge clk) begin
      exp_t e;
      int   d, w;
      logic lt;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, pend: 1'b0, fs: 1'b0};
      if (reset) begin
         m_pos = 0;
         m_act_d = '0; m_act_en = '0; m_act_dp = '0;
         m_sh_d = '0;  m_sh_en = '0;  m_sh_dp = '0;
         m_pend = 1'b0;
      end else begin
         e.fs = (m_pos == 0);
         if (m_pos == 0) begin
            if (load) begin
               m_act_d = digits_i; m_act_en = dig_en_i; m_act_dp = dp_i;
            end else if (m_pend) begin
               m_act_d = m_sh_d; m_act_en = m_sh_en; m_act_dp = m_sh_dp;
            end
            m_pend = 1'b0;
         end else if (load) begin
            m_sh_d = digits_i; m_sh_en = dig_en_i; m_sh_dp = dp_i;
            m_pend = 1'b1;
         end
         d  = m_pos / DC;
         w  = m_pos % DC;
         lt = (w >= BC) && m_act_en[d];
`ifdef SEG7_DIM_EN
         lt = lt && ((w % 16) < int'(brightness));
`endif
         if (lt) begin
            e.an    = 4'hF;
            e.an[d] = 1'b0;
            e.seg   = glyph[m_act_d[4*d +: 4]];
            e.dp    = ~m_act_dp[d];
         end
         e.pend = m_pend;
         m_pos  = (m_pos + 1) % FRAME;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         nchk++;
         if ({an, seg, dp, pending, frame_start} !== {e.an, e.seg, e.dp, e.pend, e.fs}) begin
            nerr++;
            $display("FAIL scoreboard t=%0t got an=%h seg=%h dp=%b pend=%b fs=%b, expected an=%h seg=%h dp=%b pend=%b fs=%b",
                     $time, an, seg, dp, pending, frame_start, e.an, e.seg, e.dp, e.pend, e.fs);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      nchk++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic wait_fs();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_start !== 1'b1 && n < 2 * FRAME);
      if (frame_start !== 1'b1) chk("frame_start_timeout", 16'(frame_start), 16'h1);
   endtask

   task automatic drive_load(input logic [15:0] dg, input logic [3:0] en, input logic [3:0] p);
      digits_i = dg; dig_en_i = en; dp_i = p; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  en;
      logic [3:0]  dpv;
      logic        pre;
      logic [3:0]  an0;
      logic [6:0]  seg0;
      logic        dp0;
      logic [6:0]  seg1;
   } vec_t;

   vec_t vecs [3];

   initial begin
      int lit_cnt [ND];
      int a_cnt, fs_cnt, dark_bad, tot, explit;

      vecs[0] = '{16'h1234, 4'hF,    4'b0001, 1'b0, 4'b1110, 7'h19, 1'b0, 7'h30};
      vecs[1] = '{16'h8888, 4'b1011, 4'b0000, 1'b0, 4'b1110, 7'h00, 1'b1, 7'h00};
      vecs[2] = '{16'h5555, 4'hF,    4'b0000, 1'b1, 4'b1110, 7'h12, 1'b1, 7'h12};

      reset = 1'b1; load = 1'b0; digits_i = '0; dig_en_i = '0; dp_i = '0;
`ifdef SEG7_DIM_EN
      brightness = 4'hF;
`endif
      repeat (3) @(negedge clk);
      chk("reset_an", 16'(an), 16'hF);
      chk("reset_seg", 16'(seg), 16'h7F);
      chk("reset_dp", 16'(dp), 16'h1);
      chk("reset_pending", 16'(pending), 16'h0);
      chk("reset_fs", 16'(frame_start), 16'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("first_fs", 16'(frame_start), 16'h1);
      fs_cnt = 0; dark_bad = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         if (frame_start) fs_cnt++;
         if (an != 4'hF) dark_bad++;
      end
      chk("fs_per_2frames", 16'(fs_cnt), 16'd2);
      chk("dark_after_reset", 16'(dark_bad), 16'd0);

      foreach (vecs[i]) begin
         wait_fs();
         repeat (10) @(negedge clk);
         if (vecs[i].pre) begin
            drive_load(16'hAAAA, 4'hF, 4'h0);
            repeat (2) @(negedge clk);
         end
         drive_load(vecs[i].digits, vecs[i].en, vecs[i].dpv);
         chk($sformatf("v%0d_pending_set", i), 16'(pending), 16'h1);
         wait_fs();
         chk($sformatf("v%0d_pending_clr", i), 16'(pending), 16'h0);
         for (int d = 0; d < ND; d++) lit_cnt[d] = 0;
         a_cnt = 0;
         for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            for (int d = 0; d < ND; d++) if (an[d] == 1'b0) lit_cnt[d]++;
            if (seg == 7'h08) a_cnt++;
            if (k == BC) begin
               chk($sformatf("v%0d_slot0_an", i), 16'(an), 16'(vecs[i].an0));
               chk($sformatf("v%0d_slot0_seg", i), 16'(seg), 16'(vecs[i].seg0));
               chk($sformatf("v%0d_slot0_dp", i), 16'(dp), 16'(vecs[i].dp0));
            end
            if (k == DC + BC) chk($sformatf("v%0d_slot1_seg", i), 16'(seg), 16'(vecs[i].seg1));
         end
         for (int d = 0; d < ND; d++)
            chk($sformatf("v%0d_lit_digit%0d", i, d), 16'(lit_cnt[d]),
                vecs[i].en[d] ? 16'(DC - BC) : 16'd0);
         chk($sformatf("v%0d_no_A", i), 16'(a_cnt), 16'd0);
      end

      // Load exactly on the commit cycle: the next edge is the commit point.
      drive_load(16'hFFFF, 4'hF, 4'h0);
      chk("commit_load_fs", 16'(frame_start), 16'h1);
      chk("commit_load_pending", 16'(pending), 16'h0);
      repeat (BC) @(negedge clk);
      chk("commit_load_seg", 16'(seg), 16'h0E);
      chk("commit_load_an", 16'(an), 16'hE);

      // Reset sampled with counters at slot 2, cycle 5.
      repeat (2 * DC + 5 - 1 - BC) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_an", 16'(an), 16'hF);
      chk("midreset_pending", 16'(pending), 16'h0);
      reset = 1'b0;
      drive_load(16'h1234, 4'hF, 4'h0);
      chk("postreset_fs", 16'(frame_start), 16'h1);
      chk("postreset_blank0", 16'(an), 16'hF);
      @(negedge clk);
      chk("postreset_blank1", 16'(an), 16'hF);
      @(negedge clk);
      chk("postreset_digit0_an", 16'(an), 16'hE);
      chk("postreset_digit0_seg", 16'(seg), 16'h19);

`ifdef SEG7_DIM_EN
      foreach (vecs[j]) begin
         if (j < 2) begin
            brightness = (j == 0) ? 4'd4 : 4'd0;
            explit = 0;
            for (int w = BC; w < DC; w++) if (w < int'(brightness)) explit++;
            wait_fs();
            tot = 0;
            for (int k = 0; k < FRAME; k++) begin
               if (k > 0) @(negedge clk);
               for (int d = 0; d < ND; d++) if (an[d] == 1'b0) tot++;
            end
            chk($sformatf("dim_b%0d_lit", brightness), 16'(tot), 16'(ND * explit));
         end
      end
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
